inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, 2-entry fetch buffer and a
// FETCH/HALT controller that parks on a misaligned PC until redirected.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_misalign
);

  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_q, rd_d;
  logic [31:0] e_pc_q [2];
  logic [31:0] e_pc_d [2];
  logic [31:0] e_inst_q [2];
  logic [31:0] e_inst_d [2];
  logic        e_mis_q [2];
  logic        e_mis_d [2];

  logic can_push;
  logic mis_push;
  logic push;
  logic pop;
  logic wr;

  // Fetch/push/pop qualifiers; fullness uses start-of-cycle count
  always_comb begin
    can_push = (state_q == FETCH) && (count_q != 2'd2)
             && !redirect_valid && !rst;
    mem_en   = can_push && (pc_q[1:0] == 2'b00);
    mis_push = can_push && (pc_q[1:0] != 2'b00);
    push     = mem_en || mis_push;
    out_valid = (count_q != 2'd0) && !redirect_valid && !rst;
    pop      = out_valid && out_ready;
    wr       = rd_q ^ count_q[0];
    mem_addr = pc_q;
  end

  // Head entry presentation, zero when the buffer is empty
  always_comb begin
    out_pc       = '0;
    out_inst     = '0;
    out_misalign = 1'b0;
    if (count_q != 2'd0) begin
      out_pc       = e_pc_q[rd_q];
      out_inst     = e_inst_q[rd_q];
      out_misalign = e_mis_q[rd_q];
    end
  end

  // FSM next state: redirect reopens fetch, misaligned PC parks
  always_comb begin
    state_d = state_q;
    if (redirect_valid) state_d = FETCH;
    else if (mis_push)  state_d = HALT;
  end

  // PC, occupancy, pointer and buffer contents
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_d     = rd_q;
    e_pc_d   = e_pc_q;
    e_inst_d = e_inst_q;
    e_mis_d  = e_mis_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      count_d = 2'd0;
      rd_d    = 1'b0;
    end else begin
      if (mem_en) pc_d = pc_q + 32'd4;
      if (push) begin
        e_pc_d[wr]   = pc_q;
        e_inst_d[wr] = mem_en ? mem_rdata : NOP_INST;
        e_mis_d[wr]  = mis_push;
      end
      if (pop) rd_d = ~rd_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        e_pc_q[i]   <= '0;
        e_inst_q[i] <= '0;
        e_mis_q[i]  <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      e_pc_q   <= e_pc_d;
      e_inst_q <= e_inst_d;
      e_mis_q  <= e_mis_d;
    end
  end

endmodule
